// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, bus/ALU select codes, CCR bit indices and controller state
// encoding shared by cpu_control_unit, data_path and alu.
package cpu_pkg;

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_INCA = 3'b100;

    localparam logic [1:0] FROM_ALU    = 2'b00;
    localparam logic [1:0] FROM_TO_BUS = 2'b01;
    localparam logic [1:0] FROM_MEMORY = 2'b10;

    localparam logic [1:0] TO_PC = 2'b00;
    localparam logic [1:0] TO_A  = 2'b01;
    localparam logic [1:0] TO_B  = 2'b10;

    localparam int unsigned CCR_N = 3;
    localparam int unsigned CCR_Z = 2;
    localparam int unsigned CCR_V = 1;
    localparam int unsigned CCR_C = 0;

    typedef enum logic [4:0] {
        S_FETCH_0,
        S_FETCH_1,
        S_FETCH_2,
        S_DECODE_3,
        S_OPF_3,
        S_OPF_4,
        S_LDA_IMM_5,
        S_LDB_IMM_5,
        S_DIR_5,
        S_DIR_6,
        S_LDA_DIR_7,
        S_LDB_DIR_7,
        S_STA_DIR_6,
        S_STB_DIR_6,
        S_ADD_AB_3,
        S_SUB_AB_3,
        S_AND_AB_3,
        S_OR_AB_3,
        S_INCA_3,
        S_BR_3,
        S_BR_4_WAIT,
        S_BR_5,
        S_BR_4_SKIP,
        S_NOP_3,
        S_HALT
    } state_t;

    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic       ccr_load;
        logic [2:0] alu_sel;
        logic [1:0] from_sel;
        logic [1:0] to_sel;
        logic       write;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic branch_taken(input logic [7:0] op, input logic [3:0] ccr);
        return (op == OP_BRA) ||
               ((op == OP_BEQ) && ccr[CCR_Z]) ||
               ((op == OP_BMI) && ccr[CCR_N]);
    endfunction

endpackage

// File: rtl/cpu_control_outputs.sv
// cpu_control_outputs: combinational state -> datapath strobe decoder (Moore outputs).
module cpu_control_outputs
    import cpu_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH_0, S_OPF_3, S_BR_3: begin
                ctrl.to_sel   = TO_PC;
                ctrl.from_sel = FROM_TO_BUS;
                ctrl.mar_load = 1'b1;
            end
            S_FETCH_1, S_OPF_4, S_BR_4_SKIP: begin
                ctrl.pc_inc = 1'b1;
            end
            S_FETCH_2: begin
                ctrl.from_sel = FROM_MEMORY;
                ctrl.ir_load  = 1'b1;
            end
            S_LDA_IMM_5, S_LDA_DIR_7: begin
                ctrl.from_sel = FROM_MEMORY;
                ctrl.a_load   = 1'b1;
            end
            S_LDB_IMM_5, S_LDB_DIR_7: begin
                ctrl.from_sel = FROM_MEMORY;
                ctrl.b_load   = 1'b1;
            end
            S_DIR_5: begin
                ctrl.from_sel = FROM_MEMORY;
                ctrl.mar_load = 1'b1;
            end
            S_STA_DIR_6: begin
                ctrl.to_sel = TO_A;
                ctrl.write  = 1'b1;
            end
            S_STB_DIR_6: begin
                ctrl.to_sel = TO_B;
                ctrl.write  = 1'b1;
            end
            S_ADD_AB_3, S_SUB_AB_3, S_AND_AB_3, S_OR_AB_3, S_INCA_3: begin
                ctrl.to_sel   = TO_A;
                ctrl.from_sel = FROM_ALU;
                ctrl.a_load   = 1'b1;
                ctrl.ccr_load = 1'b1;
                case (state)
                    S_SUB_AB_3: ctrl.alu_sel = ALU_SUB;
                    S_AND_AB_3: ctrl.alu_sel = ALU_AND;
                    S_OR_AB_3:  ctrl.alu_sel = ALU_OR;
                    S_INCA_3:   ctrl.alu_sel = ALU_INCA;
                    default:    ctrl.alu_sel = ALU_ADD;
                endcase
            end
            S_BR_5: begin
                ctrl.from_sel = FROM_MEMORY;
                ctrl.pc_load  = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit CPU datapath.
// Build option HALT_INSN_EN: opcode 0xFF parks the controller in S_HALT until reset.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter state_t      RESET_STATE = S_FETCH_0,
    parameter int unsigned MEM_RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR,
    output logic       IR_LOAD,
    output logic       MAR_LOAD,
    output logic       PC_LOAD,
    output logic       PC_INC,
    output logic       A_LOAD,
    output logic       B_LOAD,
    output logic       CCR_LOAD,
    output logic [2:0] ALU_SEL,
    output logic [1:0] FROM_MEMORY_BUS_SEL,
    output logic [1:0] TO_MEMORY_BUS_SEL,
    output logic       write,
    output logic       halted
);

    // The wait states below assume memory data is valid one cycle after MAR loads.
    if (MEM_RD_LAT != 1) begin : g_bad_mem_rd_lat
        $error("cpu_control_unit supports only MEM_RD_LAT == 1");
    end

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_dec;
    ctrl_t  ctrl;

    always_comb begin
        state_next = S_FETCH_0;
        case (state)
            S_FETCH_0: state_next = S_FETCH_1;
            S_FETCH_1: state_next = S_FETCH_2;
            S_FETCH_2: state_next = S_DECODE_3;
            S_DECODE_3: begin
                case (IR)
                    OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR,
                    OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: state_next = S_OPF_3;
                    OP_ADD_AB: state_next = S_ADD_AB_3;
                    OP_SUB_AB: state_next = S_SUB_AB_3;
                    OP_AND_AB: state_next = S_AND_AB_3;
                    OP_OR_AB:  state_next = S_OR_AB_3;
                    OP_INCA:   state_next = S_INCA_3;
                    OP_BRA, OP_BEQ, OP_BMI: state_next = S_BR_3;
`ifdef HALT_INSN_EN
                    OP_HALT:   state_next = S_HALT;
`endif
                    default:   state_next = S_NOP_3;
                endcase
            end
            S_OPF_3: state_next = S_OPF_4;
            S_OPF_4: begin
                if (IR == OP_LDA_IMM)
                    state_next = S_LDA_IMM_5;
                else if (IR == OP_LDB_IMM)
                    state_next = S_LDB_IMM_5;
                else
                    state_next = S_DIR_5;
            end
            // Direct loads and stores share the address fetch; only loads need the read wait.
            S_DIR_5: begin
                if (IR == OP_STA_DIR)
                    state_next = S_STA_DIR_6;
                else if (IR == OP_STB_DIR)
                    state_next = S_STB_DIR_6;
                else
                    state_next = S_DIR_6;
            end
            S_DIR_6: state_next = (IR == OP_LDB_DIR) ? S_LDB_DIR_7 : S_LDA_DIR_7;
            S_BR_3:  state_next = branch_taken(IR, CCR) ? S_BR_4_WAIT : S_BR_4_SKIP;
            S_BR_4_WAIT: state_next = S_BR_5;
`ifdef HALT_INSN_EN
            S_HALT: state_next = S_HALT;
`endif
            default: state_next = S_FETCH_0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= RESET_STATE;
        else
            state <= state_next;
    end

    cpu_control_outputs u_outputs (
        .state (state),
        .ctrl  (ctrl_dec)
    );

    // Reset idles every strobe at once, even though the reset state itself drives MAR_LOAD.
    assign ctrl = reset ? ctrl_dec : CTRL_IDLE;

    assign IR_LOAD             = ctrl.ir_load;
    assign MAR_LOAD            = ctrl.mar_load;
    assign PC_LOAD             = ctrl.pc_load;
    assign PC_INC              = ctrl.pc_inc;
    assign A_LOAD              = ctrl.a_load;
    assign B_LOAD              = ctrl.b_load;
    assign CCR_LOAD            = ctrl.ccr_load;
    assign ALU_SEL             = ctrl.alu_sel;
    assign FROM_MEMORY_BUS_SEL = ctrl.from_sel;
    assign TO_MEMORY_BUS_SEL   = ctrl.to_sel;
    assign write               = ctrl.write;

`ifdef HALT_INSN_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: drives cpu_control_unit against a behavioural datapath and memory;
// fetch, store and flag-update events are scoreboarded against hand-computed expectations.
module tb_cpu_control_unit;

    logic       clk;
    logic       reset;
    logic [7:0] ir_q;
    logic [3:0] ccr_q;
    logic       IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD;
    logic [2:0] ALU_SEL;
    logic [1:0] FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL;
    logic       write, halted;

    cpu_control_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .IR                  (ir_q),
        .CCR                 (ccr_q),
        .IR_LOAD             (IR_LOAD),
        .MAR_LOAD            (MAR_LOAD),
        .PC_LOAD             (PC_LOAD),
        .PC_INC              (PC_INC),
        .A_LOAD              (A_LOAD),
        .B_LOAD              (B_LOAD),
        .CCR_LOAD            (CCR_LOAD),
        .ALU_SEL             (ALU_SEL),
        .FROM_MEMORY_BUS_SEL (FROM_MEMORY_BUS_SEL),
        .TO_MEMORY_BUS_SEL   (TO_MEMORY_BUS_SEL),
        .write               (write),
        .halted              (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural datapath: memory contents are reloaded from prog while reset is low.
    logic [7:0] prog [256];
    logic [7:0] mem  [256];
    logic [7:0] pc_q, mar_q, a_q, b_q;
    logic [7:0] a_init;
    logic [3:0] ccr_init;
    logic [7:0] to_bus, from_bus, alu_res;
    logic [8:0] alu_t;
    logic       alu_v;
    logic [3:0] alu_nzvc;
    logic [16:0] outs;

    assign outs = {IR_LOAD, MAR_LOAD, PC_LOAD, PC_INC, A_LOAD, B_LOAD, CCR_LOAD,
                   ALU_SEL, FROM_MEMORY_BUS_SEL, TO_MEMORY_BUS_SEL, write, halted};

    always_comb begin
        alu_t = '0;
        alu_v = 1'b0;
        case (ALU_SEL)
            3'b000: begin
                alu_t = {1'b0, a_q} + {1'b0, b_q};
                alu_v = (a_q[7] == b_q[7]) && (alu_t[7] != a_q[7]);
            end
            3'b001: begin
                alu_t = {1'b0, a_q} - {1'b0, b_q};
                alu_v = (a_q[7] != b_q[7]) && (alu_t[7] != a_q[7]);
            end
            3'b010: alu_t = {1'b0, a_q & b_q};
            3'b011: alu_t = {1'b0, a_q | b_q};
            3'b100: begin
                alu_t = {1'b0, a_q} + 9'd1;
                alu_v = !a_q[7] && alu_t[7];
            end
            default: alu_t = '0;
        endcase
        alu_res  = alu_t[7:0];
        alu_nzvc = {alu_res[7], alu_res == 8'h00, alu_v, alu_t[8]};
    end

    always_comb begin
        case (TO_MEMORY_BUS_SEL)
            2'b01:   to_bus = a_q;
            2'b10:   to_bus = b_q;
            default: to_bus = pc_q;
        endcase
        case (FROM_MEMORY_BUS_SEL)
            2'b00:   from_bus = alu_res;
            2'b01:   from_bus = to_bus;
            default: from_bus = mem[mar_q];
        endcase
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= 8'h00;
            mar_q <= 8'h00;
            ir_q  <= 8'h00;
            a_q   <= a_init;
            b_q   <= 8'h00;
            ccr_q <= ccr_init;
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
        end else begin
            if (IR_LOAD)  ir_q  <= from_bus;
            if (MAR_LOAD) mar_q <= from_bus;
            if (PC_LOAD)  pc_q  <= from_bus;
            if (PC_INC)   pc_q  <= mar_q + 8'd1;
            if (A_LOAD)   a_q   <= from_bus;
            if (B_LOAD)   b_q   <= from_bus;
            if (CCR_LOAD) ccr_q <= alu_nzvc;
            if (write)    mem[mar_q] <= to_bus;
        end
    end

    // Scoreboard
    localparam int EV_FETCH = 1;
    localparam int EV_WR    = 2;
    localparam int EV_CCR   = 3;

    typedef struct {
        int tag;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;
    int  last  = 0;

    function automatic string tag_name(input int tag);
        case (tag)
            EV_FETCH: return "fetch";
            EV_WR:    return "store";
            EV_CCR:   return "ccr_load";
            default:  return "unknown";
        endcase
    endfunction

    function automatic int fetch_ev(input int gap, input logic [7:0] addr);
        return (gap << 8) | int'(addr);
    endfunction

    function automatic int wr_ev(input logic [7:0] addr, input logic [7:0] data, input logic [1:0] sel);
        return int'({addr, data, sel, 6'b000000});
    endfunction

    function automatic int ccr_ev(input logic [7:0] res, input logic [3:0] nzvc);
        return int'({res, nzvc});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int tag, input int val);
        ev_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input int tag, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_%s: got 0x%0h, expected no event", tag_name(tag), val);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", tag, e.tag);
            check({tag_name(e.tag), "_value"}, val, e.val);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cyc  = 0;
            last = 0;
        end else begin
            cyc++;
            if (IR_LOAD) begin
                got_ev(EV_FETCH, fetch_ev(cyc - last, mar_q));
                last = cyc;
            end
            if (write)
                got_ev(EV_WR, int'({mar_q, to_bus, TO_MEMORY_BUS_SEL,
                                    IR_LOAD, MAR_LOAD, PC_LOAD, A_LOAD, B_LOAD, CCR_LOAD}));
            if (CCR_LOAD)
                got_ev(EV_CCR, ccr_ev(alu_res, alu_nzvc));
        end
    end

    // Stimulus helpers
    task automatic prep(input logic [7:0] a0, input logic [3:0] c0);
        reset    = 1'b0;
        a_init   = a0;
        ccr_init = c0;
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    task automatic go();
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic stop(input string name);
        reset = 1'b0;
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        prep(8'h00, 4'h0);
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", outs, 0);

        // Reset mid LDA_DIR (D6), then clean restart
        prep(8'h00, 4'h0);
        prog[0] = 8'h87; prog[1] = 8'h10; prog[16] = 8'h33;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        go(); run(7);
        reset = 1'b0;
        #1 check("reset_mid_lda_dir_outputs", outs, 0);
        stop("reset_mid_lda_dir");
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        go(); run(3);
        stop("restart_after_reset");

        // Reset while the store strobe is up
        prep(8'h5A, 4'h0);
        prog[0] = 8'h96; prog[1] = 8'h80; prog[128] = 8'hEE;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        go(); run(7);
        check("store_write_high", int'(write), 1);
        reset = 1'b0;
        #1 check("reset_mid_store_outputs", outs, 0);
        stop("reset_mid_store");

        // LDA_IMM, LDB_IMM, ADD_AB
        prep(8'h00, 4'h0);
        prog[0] = 8'h86; prog[1] = 8'h05; prog[2] = 8'h88; prog[3] = 8'h03; prog[4] = 8'h42;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h02));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h04));
        expect_ev(EV_CCR, ccr_ev(8'h08, 4'b0000));
        expect_ev(EV_FETCH, fetch_ev(5, 8'h05));
        go(); run(22);
        check("add_a", int'(a_q), 8'h08);
        check("add_b", int'(b_q), 8'h03);
        check("add_ccr", int'(ccr_q), 4'b0000);
        stop("add");

        // LDA_IMM 0xFF then INCA wraps to zero
        prep(8'h00, 4'h0);
        prog[0] = 8'h86; prog[1] = 8'hFF; prog[2] = 8'h46;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h02));
        expect_ev(EV_CCR, ccr_ev(8'h00, 4'b0101));
        expect_ev(EV_FETCH, fetch_ev(5, 8'h03));
        go(); run(15);
        check("inca_a", int'(a_q), 8'h00);
        check("inca_ccr", int'(ccr_q), 4'b0101);
        stop("inca");

        // SUB_AB with borrow: 3 - 5
        prep(8'h00, 4'h0);
        prog[0] = 8'h86; prog[1] = 8'h03; prog[2] = 8'h88; prog[3] = 8'h05; prog[4] = 8'h43;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h02));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h04));
        expect_ev(EV_CCR, ccr_ev(8'hFE, 4'b1001));
        expect_ev(EV_FETCH, fetch_ev(5, 8'h05));
        go(); run(22);
        check("sub_a", int'(a_q), 8'hFE);
        stop("sub");

        // LDA_DIR: 9-cycle instruction
        prep(8'h00, 4'h0);
        prog[0] = 8'h87; prog[1] = 8'h10; prog[16] = 8'h33;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(9, 8'h02));
        go(); run(12);
        check("lda_dir_a", int'(a_q), 8'h33);
        stop("lda_dir");

        // STA_DIR with A preset
        prep(8'h5A, 4'h0);
        prog[0] = 8'h96; prog[1] = 8'h80; prog[128] = 8'hEE;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_WR, wr_ev(8'h80, 8'h5A, 2'b01));
        expect_ev(EV_FETCH, fetch_ev(8, 8'h02));
        go(); run(8);
        check("sta_pc", int'(pc_q), 8'h02);
        check("sta_mem", int'(mem[128]), 8'h5A);
        run(3);
        stop("sta");

        // BEQ taken (Z=1)
        prep(8'h00, 4'b0100);
        prog[0] = 8'h23; prog[1] = 8'h10;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h10));
        go(); run(7);
        check("beq_taken_pc", int'(pc_q), 8'h10);
        run(3);
        stop("beq_taken");

        // BEQ not taken (Z=0, other flags set)
        prep(8'h00, 4'b1011);
        prog[0] = 8'h23; prog[1] = 8'h10;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(6, 8'h02));
        go(); run(6);
        check("beq_not_taken_pc", int'(pc_q), 8'h02);
        run(3);
        stop("beq_not_taken");

        // BMI not taken (N=0, Z=1)
        prep(8'h00, 4'b0100);
        prog[0] = 8'h21; prog[1] = 8'h10;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(6, 8'h02));
        go(); run(9);
        stop("bmi_not_taken");

        // BMI taken (N=1)
        prep(8'h00, 4'b1000);
        prog[0] = 8'h21; prog[1] = 8'h10;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
        expect_ev(EV_FETCH, fetch_ev(7, 8'h10));
        go(); run(10);
        stop("bmi_taken");

        // Opcode 0xFF
        prep(8'h00, 4'h0);
        prog[0] = 8'hFF;
        expect_ev(EV_FETCH, fetch_ev(3, 8'h00));
`ifdef HALT_INSN_EN
        go(); run(105);
        check("halt_halted", int'(halted), 1);
        check("halt_strobes", int'(outs[16:1]), 0);
`else
        expect_ev(EV_FETCH, fetch_ev(5, 8'h01));
        go(); run(8);
        check("ff_nop_halted", int'(halted), 0);
`endif
        stop("opcode_ff");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
Multi-cycle FSM sequencing the 8-bit CPU datapath (IR, MAR, PC, A, B, CCR, ALU, the two bus muxes). It consumes IR and CCR from the datapath. It drives every datapath load, increment and select strobe, plus the memory write enable. Each instruction runs fetch → decode → execute, then returns to fetch.

Parameters:
RESET_STATE, S_FETCH_0, state entered on reset
MEM_RD_LAT, 1, cycles from MAR load to valid from_memory; the only supported value is 1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low
IR  in  8  current instruction register
CCR  in  4  flags {N,Z,V,C}
IR_LOAD  out  1  load IR from FROM_MEMORY_BUS
MAR_LOAD  out  1  load MAR from FROM_MEMORY_BUS
PC_LOAD  out  1  load PC from FROM_MEMORY_BUS
PC_INC  out  1  PC <= MAR+1
A_LOAD  out  1  load A
B_LOAD  out  1  load B
CCR_LOAD  out  1  latch ALU NZVC
ALU_SEL  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 INCA
FROM_MEMORY_BUS_SEL  out  2  00 ALU, 01 TO_MEMORY_BUS, 10 from_memory
TO_MEMORY_BUS_SEL  out  2  00 PC, 01 A, 10 B
write  out  1  memory write strobe at address=MAR
halted  out  1  high in S_HALT (only with HALT_INSN_EN; otherwise tied 0)

Behaviour:
- Reset: state=S_FETCH_0; all strobes 0; ALU_SEL=000; both selects=00; halted=0. Outputs are Moore, decoded from state (and IR/CCR in decode states); one strobe set per cycle as listed.
- S_FETCH_0: TO=PC, FROM=01, MAR_LOAD.
- S_FETCH_1: PC_INC.
- S_FETCH_2: FROM=10, IR_LOAD.
- S_DECODE_3: branches on IR to the execute states.
- Operand fetch (OPF, shared): D3 TO=PC/FROM=01/MAR_LOAD; D4 PC_INC; D5 operand on from_memory.
- LDA_IMM 0x86 / LDB_IMM 0x88: OPF; D5 FROM=10 A_LOAD/B_LOAD. 7 cycles total.
- LDA_DIR 0x87 / LDB_DIR 0x89: OPF; D5 FROM=10 MAR_LOAD; D6 wait; D7 FROM=10 A_LOAD/B_LOAD. 9 cycles.
- STA_DIR 0x96 / STB_DIR 0x97: OPF; D5 FROM=10 MAR_LOAD; D6 TO=A/B, write=1. 8 cycles.
- ADD_AB 0x42 / SUB_AB 0x43 / AND_AB 0x44 / OR_AB 0x45 / INCA 0x46: D3 TO=01 (A), ALU_SEL, FROM=00, A_LOAD, CCR_LOAD. 5 cycles.
- BRA 0x20: D3 MAR<=PC; D4 wait (no PC_INC); D5 FROM=10 PC_LOAD. 7 cycles.
- BEQ 0x23 (Z=CCR[2]) / BMI 0x21 (N=CCR[3]): flag sampled in D3.
  - Taken: behaves as BRA.
  - Not taken: D3 MAR<=PC; D4 PC_INC, then fetch. 6 cycles.
- Any other opcode is a NOP: D3 returns to S_FETCH_0. 5 cycles.
- PC wraps 0xFF→0x00 naturally (datapath 8-bit add); the controller takes no special action.
- Reset asserted mid-instruction: immediate return to S_FETCH_0, strobes 0 in the same cycle. No partial write completes after reset falls.
- write is asserted for exactly one cycle per store and never coincides with any *_LOAD.

Optional Feature:
HALT_INSN_EN:
- Defined: opcode 0xFF enters S_HALT from D3. In S_HALT all strobes are 0 and halted=1, held until reset.
- Undefined: 0xFF is a NOP; halted is constant 0.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants
  - ALU_SEL codes
  - FROM/TO bus select codes
  - CCR bit indices
  - state enum (S_FETCH_0..S_FETCH_2, S_DECODE_3, per-opcode execute states, S_HALT)
- The same package is shared with data_path and alu.
- One sub-module, cpu_control_outputs: a purely combinational state→strobe decoder. The FSM register and next-state logic stay in cpu_control_unit.

Test Plan:
1. Reset low mid-LDA_DIR (state D6) → next cycle state S_FETCH_0, all strobes 0; after release, IR_LOAD pulses in cycle 3.
2. Memory {0x86,0x05,0x88,0x03,0x42} → A=0x08, CCR=0000, IR_LOAD spacing 7,7,5 cycles.
3. Memory {0x86,0xFF,0x46} → A=0x00; CCR Z=1, C=1; CCR_LOAD high exactly one cycle.
4. A=0x5A, opcode 0x96 operand 0x80 → write=1 one cycle, TO_MEMORY_BUS_SEL=01, address 0x80; next PC=0x02.
5. BEQ 0x23, operand 0x10: with Z=1 → PC=0x10; with Z=0 → PC=0x02, instruction length 6 cycles.
6. Opcode 0xFF: with HALT_INSN_EN → halted=1, no further IR_LOAD for 100 cycles; without → NOP, next fetch at PC=0x01.
